// File: rtl/uart_receiver.sv
// UART receiver: 16x oversampled 8N1 deserializer with start/stop validation.
// Emits a one-cycle strobe per good byte and per framing error.
module uart_receiver #(
    parameter int CLKS_PER_TICK = 326
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       UART_RX,
    output logic [7:0] RX_DATA,
    output logic       RX_STATUS,
    output logic       RX_FRAME_ERR
);

    localparam int TW = (CLKS_PER_TICK > 2) ? $clog2(CLKS_PER_TICK) : 1;
    localparam logic [TW-1:0] TICK_MAX = TW'(CLKS_PER_TICK - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_STOP  = 3'd3;
    localparam logic [2:0] S_BREAK = 3'd4;

    logic          sync1_q, sync2_q;
    logic          rx_s;
    logic [2:0]    state_q, state_d;
    logic [TW-1:0] tick_q, tick_d;
    logic [3:0]    samp_q, samp_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    data_q, data_d;
    logic          stat_q, stat_d;
    logic          ferr_q, ferr_d;
    logic          tick;

    assign rx_s = sync2_q;
    assign tick = (tick_q == TICK_MAX);

    always_comb begin
        state_d = state_q;
        tick_d  = tick ? '0 : tick_q + 1'b1;
        samp_d  = tick ? samp_q + 4'd1 : samp_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        data_d  = data_q;
        stat_d  = 1'b0;
        ferr_d  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                // Restarting the tick counter here phase-aligns sampling to the edge
                if (!rx_s) begin
                    tick_d  = '0;
                    samp_d  = 4'd0;
                    bit_d   = 3'd0;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (tick && samp_q == 4'd7) begin
                    if (!rx_s) begin
                        samp_d  = 4'd0;
                        state_d = S_DATA;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_DATA: begin
                if (tick && samp_q == 4'd15) begin
                    shift_d = {rx_s, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        samp_d  = 4'd0;
                        state_d = S_STOP;
                    end
                end
            end
            S_STOP: begin
                if (tick && samp_q == 4'd15) begin
                    if (rx_s) begin
                        data_d  = shift_q;
                        stat_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = S_BREAK;
                    end
                end
            end
            S_BREAK: begin
                if (rx_s) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            state_q <= S_IDLE;
            tick_q  <= '0;
            samp_q  <= 4'd0;
            bit_q   <= 3'd0;
            shift_q <= 8'h00;
            data_q  <= 8'h00;
            stat_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            sync1_q <= UART_RX;
            sync2_q <= sync1_q;
            state_q <= state_d;
            tick_q  <= tick_d;
            samp_q  <= samp_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            stat_q  <= stat_d;
            ferr_q  <= ferr_d;
        end
    end

    assign RX_DATA      = data_q;
    assign RX_STATUS    = stat_q;
    assign RX_FRAME_ERR = ferr_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Directed testbench for uart_receiver at 4 clk per tick (64 clk per bit).
// Each scenario task checks its own expectations inline.
module tb_uart_receiver;

    localparam int N   = 4;
    localparam int BIT = 16 * N;

    logic       clk;
    logic       reset;
    logic       UART_RX;
    logic [7:0] RX_DATA;
    logic       RX_STATUS;
    logic       RX_FRAME_ERR;

    int total;
    int bad;
    int cyc;
    int n_stat;
    int n_ferr;
    int n_both;
    int stat_cyc [0:7];
    logic [7:0] stat_dat [0:7];

    uart_receiver #(.CLKS_PER_TICK(N)) dut (
        .clk         (clk),
        .reset       (reset),
        .UART_RX     (UART_RX),
        .RX_DATA     (RX_DATA),
        .RX_STATUS   (RX_STATUS),
        .RX_FRAME_ERR(RX_FRAME_ERR)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse recorder, sampled 1 time unit after each rising edge
    always begin
        @(posedge clk);
        #1;
        cyc = cyc + 1;
        if (RX_STATUS && RX_FRAME_ERR) n_both = n_both + 1;
        if (RX_STATUS) begin
            if (n_stat < 8) begin
                stat_cyc[n_stat] = cyc;
                stat_dat[n_stat] = RX_DATA;
            end
            n_stat = n_stat + 1;
        end
        if (RX_FRAME_ERR) n_ferr = n_ferr + 1;
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clr_counts();
        n_stat = 0;
        n_ferr = 0;
        n_both = 0;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, input int stop_len);
        UART_RX = 1'b0;
        wait_cyc(BIT);
        for (int i = 0; i < 8; i++) begin
            UART_RX = d[i];
            wait_cyc(BIT);
        end
        UART_RX = stop;
        wait_cyc(stop_len);
    endtask

    task automatic test_reset();
        reset   = 1'b0;
        UART_RX = 1'b1;
        #1;
        total++;
        if (RX_DATA !== 8'h00) begin
            bad++;
            $display("FAIL reset_data: got %h want 00", RX_DATA);
        end
        total++;
        if (RX_STATUS !== 1'b0 || RX_FRAME_ERR !== 1'b0) begin
            bad++;
            $display("FAIL reset_pulses: got stat=%b ferr=%b want 0 0", RX_STATUS, RX_FRAME_ERR);
        end
        wait_cyc(5);
        clr_counts();
        reset = 1'b1;
        wait_cyc(2000);
        total++;
        if (n_stat != 0 || n_ferr != 0) begin
            bad++;
            $display("FAIL idle_quiet: got stat=%0d ferr=%0d want 0 0", n_stat, n_ferr);
        end
    endtask

    task automatic test_single();
        int c0;
        clr_counts();
        @(negedge clk);
        c0 = cyc;
        send_frame(8'h55, 1'b1, BIT);
        wait_cyc(100);
        total++;
        if (n_stat != 1 || n_ferr != 0) begin
            bad++;
            $display("FAIL single_count: got stat=%0d ferr=%0d want 1 0", n_stat, n_ferr);
        end
        total++;
        if (stat_dat[0] !== 8'h55) begin
            bad++;
            $display("FAIL single_data: got %h want 55", stat_dat[0]);
        end
        // Edge lands before posedge 1; 2 sync cycles + 608 + 1 register
        total++;
        if (stat_cyc[0] - c0 != 611) begin
            bad++;
            $display("FAIL single_latency: got %0d want 611", stat_cyc[0] - c0);
        end
    endtask

    task automatic test_back_to_back();
        clr_counts();
        @(negedge clk);
        send_frame(8'hA3, 1'b1, BIT);
        send_frame(8'h0F, 1'b1, BIT);
        wait_cyc(100);
        total++;
        if (n_stat != 2 || n_ferr != 0) begin
            bad++;
            $display("FAIL b2b_count: got stat=%0d ferr=%0d want 2 0", n_stat, n_ferr);
        end
        total++;
        if (stat_dat[0] !== 8'hA3 || stat_dat[1] !== 8'h0F) begin
            bad++;
            $display("FAIL b2b_data: got %h %h want a3 0f", stat_dat[0], stat_dat[1]);
        end
        total++;
        if (stat_cyc[1] - stat_cyc[0] != 640) begin
            bad++;
            $display("FAIL b2b_spacing: got %0d want 640", stat_cyc[1] - stat_cyc[0]);
        end
    endtask

    task automatic test_glitch();
        clr_counts();
        @(negedge clk);
        UART_RX = 1'b0;
        wait_cyc(20);
        UART_RX = 1'b1;
        wait_cyc(200);
        total++;
        if (n_stat != 0 || n_ferr != 0) begin
            bad++;
            $display("FAIL glitch_quiet: got stat=%0d ferr=%0d want 0 0", n_stat, n_ferr);
        end
        total++;
        if (dut.state_q !== 3'd0) begin
            bad++;
            $display("FAIL glitch_idle: got state %0d want 0", dut.state_q);
        end
        send_frame(8'h3C, 1'b1, BIT);
        wait_cyc(100);
        total++;
        if (n_stat != 1 || stat_dat[0] !== 8'h3C || RX_DATA !== 8'h3C) begin
            bad++;
            $display("FAIL glitch_next: got n=%0d data=%h want 1 3c", n_stat, RX_DATA);
        end
    endtask

    task automatic test_frame_err();
        clr_counts();
        send_frame(8'h11, 1'b1, BIT);
        wait_cyc(50);
        total++;
        if (n_stat != 1 || RX_DATA !== 8'h11) begin
            bad++;
            $display("FAIL ferr_pre: got n=%0d data=%h want 1 11", n_stat, RX_DATA);
        end
        clr_counts();
        send_frame(8'hFF, 1'b0, 300);
        UART_RX = 1'b1;
        wait_cyc(100);
        total++;
        if (n_ferr != 1 || n_stat != 0) begin
            bad++;
            $display("FAIL ferr_pulse: got ferr=%0d stat=%0d want 1 0", n_ferr, n_stat);
        end
        total++;
        if (RX_DATA !== 8'h11) begin
            bad++;
            $display("FAIL ferr_hold: got %h want 11", RX_DATA);
        end
        wait_cyc(2000);
        total++;
        if (n_ferr != 1 || n_stat != 0) begin
            bad++;
            $display("FAIL ferr_quiet: got ferr=%0d stat=%0d want 1 0", n_ferr, n_stat);
        end
    endtask

    task automatic test_reset_midframe();
        logic [7:0] d;
        d = 8'hC6;
        clr_counts();
        UART_RX = 1'b0;
        wait_cyc(BIT);
        for (int i = 0; i < 4; i++) begin
            UART_RX = d[i];
            wait_cyc(BIT);
        end
        UART_RX = d[4];
        wait_cyc(30);
        reset = 1'b0;
        #1;
        total++;
        if (RX_DATA !== 8'h00) begin
            bad++;
            $display("FAIL mid_async_clear: got %h want 00", RX_DATA);
        end
        wait_cyc(BIT - 30);
        for (int i = 5; i < 8; i++) begin
            UART_RX = d[i];
            wait_cyc(BIT);
        end
        UART_RX = 1'b1;
        wait_cyc(BIT);
        reset = 1'b1;
        wait_cyc(200);
        send_frame(8'h5A, 1'b1, BIT);
        wait_cyc(100);
        total++;
        if (n_stat != 1 || n_ferr != 0) begin
            bad++;
            $display("FAIL mid_count: got stat=%0d ferr=%0d want 1 0", n_stat, n_ferr);
        end
        total++;
        if (stat_dat[0] !== 8'h5A || RX_DATA !== 8'h5A) begin
            bad++;
            $display("FAIL mid_data: got %h want 5a", RX_DATA);
        end
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        cyc     = 0;
        n_stat  = 0;
        n_ferr  = 0;
        n_both  = 0;
        reset   = 1'b0;
        UART_RX = 1'b1;
        test_reset();
        test_single();
        test_back_to_back();
        test_glitch();
        test_frame_err();
        test_reset_midframe();
        total++;
        if (n_both != 0) begin
            bad++;
            $display("FAIL overlap: got %0d want 0", n_both);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
